// File: rtl/dbus_sram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbus_sram_bridge_pkg
// Brief    : Shared types and constants for the dbus-to-SRAM-like bridge:
//            FSM state encoding and the SRAM-like transfer size codes.
// Revision : 1.0 - initial release
// ============================================================================
package dbus_sram_bridge_pkg;

   // Bridge FSM states, explicitly two bits wide.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // SRAM-like data_size codes.
   localparam logic [1:0] c_sz_byte = 2'd0;
   localparam logic [1:0] c_sz_half = 2'd1;
   localparam logic [1:0] c_sz_word = 2'd2;

endpackage : dbus_sram_bridge_pkg
`default_nettype wire

// File: rtl/dbus_sram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : dbus_sram_bridge_if
// Brief    : Bundles the MMU-side dbus, the pipeline stall pair and the
//            SRAM-like request/response channel seen by the bridge.
//            'slave' is the bridge's view (it serves dbus requests);
//            'master' is the surrounding system (MMU, pipeline, SRAM).
// Revision : 1.0 - initial release
// ============================================================================
interface dbus_sram_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // MMU-side dbus
   logic                  dbus_en;
   logic [DATA_W/8-1:0]   dbus_wen;
   logic [ADDR_W-1:0]     dbus_paddr;
   logic [DATA_W-1:0]     dbus_wdata;
   logic [DATA_W-1:0]     dbus_rdata;
   logic                  dbus_streq;
   logic                  pipe_stall;
   // SRAM-like channel
   logic                  data_req;
   logic                  data_wr;
   logic [1:0]            data_size;
   logic [ADDR_W-1:0]     data_addr;
   logic [DATA_W-1:0]     data_wdata;
   logic                  data_addr_ok;
   logic [DATA_W-1:0]     data_rdata;
   logic                  data_data_ok;

   modport slave (
      input  dbus_en, dbus_wen, dbus_paddr, dbus_wdata, pipe_stall,
      input  data_addr_ok, data_rdata, data_data_ok,
      output dbus_rdata, dbus_streq,
      output data_req, data_wr, data_size, data_addr, data_wdata
   );

   modport master (
      output dbus_en, dbus_wen, dbus_paddr, dbus_wdata, pipe_stall,
      output data_addr_ok, data_rdata, data_data_ok,
      input  dbus_rdata, dbus_streq,
      input  data_req, data_wr, data_size, data_addr, data_wdata
   );

endinterface : dbus_sram_bridge_if
`default_nettype wire

// File: rtl/dbus_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dbus_sram_bridge
// Brief    : Turns the single-cycle MMU dbus request into an SRAM-like
//            req/addr_ok + data_ok transaction, stalling the pipeline until
//            the access completes and holding load data while MEM is held.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_sram_bridge
   import dbus_sram_bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   dbus_sram_bridge_if.slave      bus
);

   localparam int c_be_w = DATA_W / 8;

   // Single-lane enables are byte accesses, the two aligned half-word pairs
   // are half accesses; reads and every other pattern go out as full words.
   function automatic logic [1:0] wen_to_size(input logic [c_be_w-1:0] wen);
      logic [1:0] size;
      size = c_sz_word;
      if ($countones(wen) == 1) begin
         size = c_sz_byte;
      end else if ((wen == c_be_w'(4'b0011)) || (wen == c_be_w'(4'b1100))) begin
         size = c_sz_half;
      end
      return size;
   endfunction

   // Word transfers present a word-aligned address; the pipeline picks bytes.
   function automatic logic [ADDR_W-1:0] req_addr(input logic [ADDR_W-1:0] paddr,
                                                  input logic [1:0]        size);
      logic [ADDR_W-1:0] addr;
      addr = paddr;
      if (size == c_sz_word) begin
         addr = paddr & ~ADDR_W'(c_be_w - 1);
      end
      return addr;
   endfunction

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_streq;
   logic [1:0]          w_size;
   logic                r_req;
   logic                r_wr;
   logic [1:0]          r_size;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;

   assign w_size = wen_to_size(bus.dbus_wen);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and stall request; the access is committed once REQ is entered.
   always_comb begin
      w_state_nxt = r_state;
      w_streq     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_streq = bus.dbus_en;
            if (bus.dbus_en) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            w_streq = 1'b1;
            if (bus.data_addr_ok) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            w_streq = 1'b1;
            if (bus.data_data_ok) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (!bus.pipe_stall) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Registered request: valid exactly while in REQ, fields latched on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req   <= 1'b0;
         r_wr    <= 1'b0;
         r_size  <= c_sz_byte;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_req <= (w_state_nxt == S_REQ);
         if ((r_state == S_IDLE) && bus.dbus_en) begin
            r_wr    <= |bus.dbus_wen;
            r_size  <= w_size;
            r_addr  <= req_addr(bus.dbus_paddr, w_size);
            r_wdata <= bus.dbus_wdata;
         end
      end
   end

   // Load data capture; stores leave the previous load value in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if ((r_state == S_WAIT) && bus.data_data_ok && !r_wr) begin
         r_rdata <= bus.data_rdata;
      end
   end

   assign bus.data_req   = r_req;
   assign bus.data_wr    = r_wr;
   assign bus.data_size  = r_size;
   assign bus.data_addr  = r_addr;
   assign bus.data_wdata = r_wdata;
   assign bus.dbus_rdata = r_rdata;
   assign bus.dbus_streq = w_streq;

endmodule : dbus_sram_bridge
`default_nettype wire

// File: tb/tb_dbus_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_sram_bridge
// Brief    : Self-checking bench for dbus_sram_bridge: directed scenarios
//            with literal expectations, then randomized traffic against a
//            transaction-level reference model with a scripted SRAM slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_sram_bridge;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   dbus_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dbus_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   localparam int PH_IDLE = 0, PH_ASK = 1, PH_WAIT = 2, PH_DONE = 3;

   function automatic logic [1:0] ref_size(input logic [3:0] wen);
      if (wen inside {4'd1, 4'd2, 4'd4, 4'd8}) return 2'd0;
      if (wen inside {4'd3, 4'd12})            return 2'd1;
      return 2'd2;
   endfunction

   function automatic logic [31:0] ref_addr(input logic [3:0] wen, input logic [31:0] pa);
      if (ref_size(wen) == 2'd2) return pa - (pa % 32'd4);
      return pa;
   endfunction

   int          m_phase = PH_IDLE;
   logic        m_wr    = 1'b0;
   logic [1:0]  m_sz    = 2'd0;
   logic [31:0] m_addr  = 32'd0;
   logic [31:0] m_wdata = 32'd0;
   logic [31:0] m_rdata = 32'd0;

   // Model advances on the same edge as the DUT, from the spec's transaction rules.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= PH_IDLE;
         m_wr    <= 1'b0;
         m_sz    <= 2'd0;
         m_addr  <= 32'd0;
         m_wdata <= 32'd0;
         m_rdata <= 32'd0;
      end else begin
         case (m_phase)
            PH_IDLE: if (bus.dbus_en) begin
               m_phase <= PH_ASK;
               m_wr    <= (bus.dbus_wen != 4'd0);
               m_sz    <= ref_size(bus.dbus_wen);
               m_addr  <= ref_addr(bus.dbus_wen, bus.dbus_paddr);
               m_wdata <= bus.dbus_wdata;
            end
            PH_ASK:  if (bus.data_addr_ok) m_phase <= PH_WAIT;
            PH_WAIT: if (bus.data_data_ok) begin
               m_phase <= PH_DONE;
               if (!m_wr) m_rdata <= bus.data_rdata;
            end
            default: if (!bus.pipe_stall) m_phase <= PH_IDLE;
         endcase
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("data_req",   bus.data_req,   32'(m_phase == PH_ASK));
      chk("data_wr",    bus.data_wr,    32'(m_wr));
      chk("data_size",  bus.data_size,  32'(m_sz));
      chk("data_addr",  bus.data_addr,  m_addr);
      chk("data_wdata", bus.data_wdata, m_wdata);
      chk("dbus_rdata", bus.dbus_rdata, m_rdata);
      chk("dbus_streq", bus.dbus_streq,
          32'((m_phase == PH_ASK) || (m_phase == PH_WAIT) ||
              ((m_phase == PH_IDLE) && bus.dbus_en && !rst)));
   end

   // ---------------- SRAM-like slave ----------------
   int          a_dly    = 0;
   int          d_dly    = 1;
   bit          rnd_mode = 1'b0;
   logic [31:0] s_rdata  = 32'd0;
   bit          s_out    = 1'b0;
   int          s_cnt    = 0;
   int          s_wait   = 0;
   bit          s_acc;

   initial begin
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      bus.data_rdata   = 32'd0;
      forever begin
         @(negedge clk);
         s_acc = bus.data_req && bus.data_addr_ok && !rst;
         @(posedge clk);
         #1;
         bus.data_addr_ok = 1'b0;
         bus.data_data_ok = 1'b0;
         if (s_acc) begin
            s_out  = 1'b1;
            s_cnt  = d_dly;
            s_wait = 0;
            if (rnd_mode) begin
               a_dly = $urandom_range(0, 4);
               d_dly = $urandom_range(1, 3);
            end
         end
         if (s_out) begin
            s_cnt--;
            if (s_cnt == 0) begin
               bus.data_data_ok = 1'b1;
               bus.data_rdata   = rnd_mode ? $urandom : s_rdata;
               s_out            = 1'b0;
            end
         end else if (bus.data_req) begin
            if (s_wait >= a_dly) bus.data_addr_ok = 1'b1;
            else                 s_wait++;
         end else if (rnd_mode && ($urandom_range(0, 7) == 0)) begin
            bus.data_data_ok = 1'b1;
            bus.data_rdata   = $urandom;
         end
      end
   end

   // ---------------- directed transaction driver ----------------
   task automatic txn(input logic [3:0] wen, input logic [31:0] pa, input logic [31:0] wd,
                      input int ncyc, input int en_last, input int stall_last, input int rst_at,
                      output int n_req, output int n_streq);
      n_req   = 0;
      n_streq = 0;
      bus.dbus_en    = 1'b1;
      bus.dbus_wen   = wen;
      bus.dbus_paddr = pa;
      bus.dbus_wdata = wd;
      bus.pipe_stall = (stall_last >= 0);
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (bus.data_req)   n_req++;
         if (bus.dbus_streq) n_streq++;
         @(posedge clk);
         #1;
         rst            = (i + 1 == rst_at);
         bus.dbus_en    = (i + 1 <= en_last) && !rst;
         bus.pipe_stall = (i + 1 <= stall_last);
      end
   endtask

   logic [3:0] wen_tbl [8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15};
   int nr, ns;

   initial begin
      bus.dbus_en    = 1'b0;
      bus.dbus_wen   = 4'd0;
      bus.dbus_paddr = 32'd0;
      bus.dbus_wdata = 32'd0;
      bus.pipe_stall = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset data_req",   bus.data_req,   32'd0);
      chk("reset dbus_rdata", bus.dbus_rdata, 32'd0);
      chk("reset streq",      bus.dbus_streq, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: plain read, fastest slave
      a_dly = 0; d_dly = 1; s_rdata = 32'hDEADBEEF;
      txn(4'b0000, 32'h0000_1004, 32'd0, 5, 0, -1, -1, nr, ns);
      chk("t1 req cycles",   nr, 32'd1);
      chk("t1 streq cycles", ns, 32'd3);
      chk("t1 rdata",  bus.dbus_rdata, 32'hDEADBEEF);
      chk("t1 addr",   bus.data_addr,  32'h0000_1004);
      chk("t1 size",   bus.data_size,  32'd2);

      // 2: byte write; load data must not change
      s_rdata = 32'h1234_5678;
      txn(4'b0100, 32'h0000_2002, 32'h00AB_0000, 5, 0, -1, -1, nr, ns);
      chk("t2 wr",    bus.data_wr,    32'd1);
      chk("t2 size",  bus.data_size,  32'd0);
      chk("t2 addr",  bus.data_addr,  32'h0000_2002);
      chk("t2 wdata", bus.data_wdata, 32'h00AB_0000);
      chk("t2 rdata", bus.dbus_rdata, 32'hDEADBEEF);

      // 3: addr_ok delayed 4 cycles, full-word write to an unaligned address
      a_dly = 4;
      txn(4'b1111, 32'h0000_3007, 32'h1122_3344, 9, 0, -1, -1, nr, ns);
      chk("t3 req cycles",   nr, 32'd5);
      chk("t3 streq cycles", ns, 32'd7);
      chk("t3 addr", bus.data_addr, 32'h0000_3004);
      a_dly = 0;

      // 4: pipeline held in DONE for 3 cycles
      s_rdata = 32'hCAFE_F00D;
      txn(4'b0000, 32'h0000_0040, 32'd0, 8, 0, 5, -1, nr, ns);
      chk("t4 req cycles",   nr, 32'd1);
      chk("t4 streq cycles", ns, 32'd3);
      chk("t4 rdata", bus.dbus_rdata, 32'hCAFE_F00D);

      // 5: dbus_en dropped during WAIT
      d_dly = 3; s_rdata = 32'h55AA_55AA;
      txn(4'b0000, 32'h0000_0050, 32'd0, 8, 2, -1, -1, nr, ns);
      chk("t5 req cycles",   nr, 32'd1);
      chk("t5 streq cycles", ns, 32'd5);
      chk("t5 rdata", bus.dbus_rdata, 32'h55AA_55AA);

      // 6: reset in WAIT, stray data_ok afterwards, then a clean read
      s_rdata = 32'h7777_7777;
      txn(4'b0000, 32'h0000_0080, 32'd0, 7, 0, -1, 2, nr, ns);
      chk("t6 req cycles",   nr, 32'd1);
      chk("t6 streq cycles", ns, 32'd2);
      chk("t6 rdata", bus.dbus_rdata, 32'd0);
      chk("t6 addr",  bus.data_addr,  32'd0);
      d_dly = 1; s_rdata = 32'h0BAD_F00D;
      txn(4'b0000, 32'h0000_0084, 32'd0, 5, 0, -1, -1, nr, ns);
      chk("t6b req cycles", nr, 32'd1);
      chk("t6b rdata", bus.dbus_rdata, 32'h0BAD_F00D);

      // Randomized traffic
      rnd_mode = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rst            = ($urandom_range(0, 63) == 0);
         bus.dbus_en    = !rst && ($urandom_range(0, 1) == 1);
         bus.dbus_wen   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : wen_tbl[$urandom_range(0, 7)];
         bus.dbus_paddr = $urandom;
         bus.dbus_wdata = $urandom;
         bus.pipe_stall = ($urandom_range(0, 2) == 0);
         @(posedge clk);
         #1;
      end
      rst            = 1'b0;
      bus.dbus_en    = 1'b0;
      bus.pipe_stall = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_dbus_sram_bridge
`default_nettype wire
